// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding, reset
// address default and PC arithmetic helpers.
package fetch_pkg;

  typedef enum logic [1:0] {
    StReq   = 2'd0,
    StWait  = 2'd1,
    StHold  = 2'd2,
    StFlush = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DefaultResetPc = 32'h8002_0000;
  localparam int unsigned InsnBytes      = 4;

  // Sequential fetch address; wraps modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] cur);
    return cur + 32'(InsnBytes);
  endfunction

  function automatic logic [31:0] align_pc(input logic [31:0] target);
    return {target[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// One-entry pc/insn holding register used when a response arrives while the
// output slot is still occupied by a stalled instruction.
module fetch_buffer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        drain_i,
  input  logic        clear_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] insn_i,
  output logic        full_o,
  output logic [31:0] pc_o,
  output logic [31:0] insn_o
);

  logic        full_q;
  logic [31:0] pc_q;
  logic [31:0] insn_q;

  // Clear wins over load so a redirect discards a same-cycle capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      pc_q   <= '0;
      insn_q <= '0;
    end else if (clear_i) begin
      full_q <= 1'b0;
    end else if (load_i) begin
      full_q <= 1'b1;
      pc_q   <= pc_i;
      insn_q <= insn_i;
    end else if (drain_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;
  assign pc_o   = pc_q;
  assign insn_o = insn_q;

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: single outstanding imem read, registered pc/insn to
// decode, downstream stall and redirect with flush of in-flight reads.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefaultResetPc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] insn,
  output logic        valid_insn
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fpc_q, fpc_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  insn_q, insn_d;
  logic         valid_q, valid_d;

  logic         buf_load, buf_drain, buf_clear, buf_full;
  logic [31:0]  buf_pc, buf_insn;
  logic         slot_free;

  fetch_buffer u_buffer (
    .clk_i   (clk),
    .rst_i   (reset),
    .load_i  (buf_load),
    .drain_i (buf_drain),
    .clear_i (buf_clear),
    .pc_i    (fpc_q),
    .insn_i  (imem_rdata),
    .full_o  (buf_full),
    .pc_o    (buf_pc),
    .insn_o  (buf_insn)
  );

  assign slot_free = ~valid_q | ~stall;

  always_comb begin
    state_d   = state_q;
    fpc_d     = fpc_q;
    pc_d      = pc_q;
    insn_d    = insn_q;
    // The presented instruction is consumed whenever decode is not stalling.
    valid_d   = valid_q & stall;
    buf_load  = 1'b0;
    buf_drain = 1'b0;
    buf_clear = 1'b0;

    if (redirect) begin
      fpc_d     = align_pc(redirect_pc);
      valid_d   = 1'b0;
      buf_clear = 1'b1;
      unique case (state_q)
        StReq:   state_d = StFlush;
        StWait:  state_d = imem_rvalid ? StReq : StFlush;
        StHold:  state_d = StReq;
        StFlush: state_d = imem_rvalid ? StReq : StFlush;
        default: state_d = StReq;
      endcase
    end else begin
      // imem_rvalid in StReq/StHold is a protocol violation and is ignored.
      unique case (state_q)
        StReq: state_d = StWait;
        StWait: begin
          if (imem_rvalid) begin
            if (slot_free) begin
              pc_d    = fpc_q;
              insn_d  = imem_rdata;
              valid_d = 1'b1;
              fpc_d   = next_pc(fpc_q);
              state_d = StReq;
            end else begin
              buf_load = 1'b1;
              state_d  = StHold;
            end
          end
        end
        StHold: begin
          if (!stall && buf_full) begin
            pc_d      = buf_pc;
            insn_d    = buf_insn;
            valid_d   = 1'b1;
            fpc_d     = next_pc(fpc_q);
            buf_drain = 1'b1;
            state_d   = StReq;
          end
        end
        StFlush: begin
          if (imem_rvalid) state_d = StReq;
        end
        default: state_d = StReq;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StReq;
      fpc_q   <= RESET_PC;
      pc_q    <= '0;
      insn_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      pc_q    <= pc_d;
      insn_q  <= insn_d;
      valid_q <= valid_d;
    end
  end

  // Reset gates the request so nothing is issued while the stage is held.
  assign imem_req   = (state_q == StReq) & ~reset;
  assign imem_addr  = fpc_q;
  assign pc         = pc_q;
  assign insn       = insn_q;
  assign valid_insn = valid_q;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: latency-parameterised memory model, a
// scoreboard of expected pc/insn, a vector table and hand-written corner cases.
module tb_fetch;

  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pc, insn;
  logic        valid_insn;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_pc, w_insn;

  fetch dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .insn        (insn),
    .valid_insn  (valid_insn)
  );

  fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (w_req),
    .imem_addr   (w_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc          (w_pc),
    .insn        (w_insn),
    .valid_insn  (w_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
  } exp_t;

  typedef struct {
    int          lat;
    logic [15:0] stall_mask;
    int          redir_cyc;
    logic [31:0] redir_pc;
    int          n;
  } vec_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc;
  int          consumed;
  int          lat;
  bit          pend;
  logic [31:0] pend_addr;
  int          pend_cnt;
  bit          force_rv;
  logic [31:0] force_data;

  // Address 0x..08 returns an all-zero word so noop pass-through is exercised.
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a[7:0] == 8'h08) return 32'h0;
    return {a[15:0], ~a[15:0]} ^ 32'h0000_5A5A;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sb_start(input logic [31:0] start);
    exp_t e;
    sbq.delete();
    for (int i = 0; i < 24; i++) begin
      e.pc   = start + 32'(4 * i);
      e.insn = memf(e.pc);
      sbq.push_back(e);
    end
  endtask

  // One clock: drive memory response, track requests, score consumption.
  task automatic cycle();
    exp_t        e;
    logic [31:0] tgt;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0BAD_F00D;
    if (force_rv) begin
      imem_rvalid = 1'b1;
      imem_rdata  = force_data;
      force_rv    = 1'b0;
    end else if (pend) begin
      if (pend_cnt <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memf(pend_addr);
        pend        = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    if (imem_req) begin
      checkb("single_outstanding", pend, 1'b0);
      pend      = 1'b1;
      pend_addr = imem_addr;
      pend_cnt  = lat;
    end
    if (redirect) begin
      tgt = redirect_pc;
      tgt[1:0] = 2'b00;
      sb_start(tgt);
      consumed = 0;
    end else if (valid_insn && !stall) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_insn: got pc %h expected none (cycle %0d)", pc, cyc);
      end else begin
        e = sbq.pop_front();
        check32("sb_pc", pc, e.pc);
        check32("sb_insn", insn, e.insn);
      end
      consumed++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_dut();
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    pend        = 1'b0;
    force_rv    = 1'b0;
    #1;
    checkb("rst_req", imem_req, 1'b0);
    checkb("rst_valid", valid_insn, 1'b0);
    check32("rst_pc", pc, 32'h0);
    check32("rst_insn", insn, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    sb_start(32'h8002_0000);
    cyc      = 0;
    consumed = 0;
  endtask

  vec_t vecs[8];

  initial begin
    logic [6:0] exp_v;
    logic [6:0] exp_r;
    bit         seen;

    vecs[0] = '{1, 16'h0000, -1, 32'h0,         6};
    vecs[1] = '{2, 16'h0F0F, -1, 32'h0,         6};
    vecs[2] = '{3, 16'h3333, -1, 32'h0,         5};
    vecs[3] = '{1, 16'h0000,  0, 32'h8004_0002, 5};  // redirect while REQ
    vecs[4] = '{2, 16'h00F0,  2, 32'h8004_1000, 5};  // redirect with rvalid in WAIT
    vecs[5] = '{1, 16'h003C,  4, 32'h1234_5677, 5};  // redirect from HOLD
    vecs[6] = '{4, 16'h0000,  6, 32'h8000_0020, 4};  // FLUSH then late rvalid
    vecs[7] = '{2, 16'h5555,  5, 32'hFFFF_FFF8, 4};  // target wraps

    // Basic timing, L=1, no stall; dut_w checks address wrap.
    lat = 1;
    reset_dut();
    exp_v = 7'b1010100;
    exp_r = 7'b1010101;
    for (int i = 0; i < 7; i++) begin
      checkb("t1_valid", valid_insn, exp_v[i]);
      checkb("t1_req", imem_req, exp_r[i]);
      if (exp_r[i]) begin
        check32("t1_addr", imem_addr, 32'h8002_0000 + 32'(i * 2));
        check32("wrap_addr", w_addr, 32'hFFFF_FFFC + 32'(i * 2));
      end
      if (exp_v[i]) check32("wrap_pc", w_pc, 32'hFFFF_FFFC + 32'((i - 2) * 2));
      if (i == 2) check32("wrap_insn", w_insn, memf(32'h8002_0000));
      cycle();
    end

    // Stall held 5 cycles with a second response buffered.
    lat = 1;
    reset_dut();
    for (int i = 0; i < 13; i++) begin
      stall = (i >= 2 && i <= 6);
      if (i >= 3 && i <= 6) begin
        checkb("stall_valid", valid_insn, 1'b1);
        check32("stall_pc", pc, 32'h8002_0000);
      end
      if (i == 8) begin
        checkb("release_valid", valid_insn, 1'b1);
        check32("release_pc", pc, 32'h8002_0004);
      end
      cycle();
    end
    check32("stall_count", 32'(consumed), 32'd4);

    // Redirect while WAIT, L=3: stale response dropped.
    lat = 3;
    reset_dut();
    cycle();
    redirect    = 1'b1;
    redirect_pc = 32'h8002_0103;
    cycle();
    redirect = 1'b0;
    seen     = 1'b0;
    for (int i = 0; i < 40 && consumed < 2; i++) begin
      if (imem_req && !seen) begin
        seen = 1'b1;
        check32("flush_addr", imem_addr, 32'h8002_0100);
        check32("flush_cycle", 32'(cyc), 32'd4);
      end
      cycle();
    end
    checkb("flush_done", consumed >= 2, 1'b1);

    // Redirect same cycle as rvalid with output full and stall held.
    lat = 1;
    reset_dut();
    cycle();
    cycle();
    stall = 1'b1;
    cycle();
    redirect    = 1'b1;
    redirect_pc = 32'h8003_0010;
    cycle();
    redirect = 1'b0;
    stall    = 1'b0;
    checkb("rsame_valid", valid_insn, 1'b0);
    checkb("rsame_req", imem_req, 1'b1);
    check32("rsame_addr", imem_addr, 32'h8003_0010);
    for (int i = 0; i < 40 && consumed < 3; i++) cycle();
    checkb("rsame_done", consumed >= 3, 1'b1);

    // Reset mid-WAIT; stale rvalid arrives in REQ after release.
    lat = 3;
    reset_dut();
    cycle();
    cycle();
    reset_dut();
    force_rv   = 1'b1;
    force_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 40 && consumed < 2; i++) cycle();
    checkb("mid_rst_done", consumed >= 2, 1'b1);

    // Vector table: latency, stall pattern, optional redirect.
    foreach (vecs[k]) begin
      lat = vecs[k].lat;
      reset_dut();
      for (int i = 0; i < 300; i++) begin
        if (consumed >= vecs[k].n && cyc > vecs[k].redir_cyc) break;
        stall       = vecs[k].stall_mask[cyc % 16];
        redirect    = (cyc == vecs[k].redir_cyc);
        redirect_pc = vecs[k].redir_pc;
        cycle();
      end
      redirect = 1'b0;
      checkb("vec_done", consumed >= vecs[k].n, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
